// File: rtl/apb_debug_reg_bridge.sv
// apb_debug_reg_bridge
//   APB3/APB4 target for the debug path. Each accepted APB transfer is
//   checked for protection and alignment, then turned into a single
//   request/acknowledge access on a simple register bus. Wait states are
//   inserted through pready, register-bus accesses are bounded by a
//   timeout counter, and failures are reported on pslverr.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   paddr/psel/penable      APB address and handshake
//   pwrite/pwdata/pstrb     APB write direction, data, byte strobes
//   pprot                   APB protection (bit 1 = non-secure)
//   pready/prdata/pslverr   APB completion, read data, error
//   reg_req/reg_we          register-bus request level and write enable
//   reg_addr/reg_wdata      captured address and write data
//   reg_be                  byte enables (all ones for reads)
//   reg_ack/reg_rdata/reg_err  register-bus completion, read data, error
module apb_debug_reg_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STRB_W  = DATA_W / 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [2:0]        pprot,
  input  logic [STRB_W-1:0] pstrb,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [STRB_W-1:0] reg_be,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_err
);

  localparam int unsigned OFF_W = $clog2(STRB_W);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pready_q, pslverr_q, reg_req_q, reg_we_q;
  logic [DATA_W-1:0]  prdata_q, reg_wdata_q;
  logic [ADDR_W-1:0]  reg_addr_q;
  logic [STRB_W-1:0]  reg_be_q;

  logic setup, xfer_err, null_wr, timeout;

  // Only the non-secure bit of pprot affects the transfer.
  logic unused_prot;
  assign unused_prot = ^{pprot[2], pprot[0]};

  always_comb begin
    setup    = psel && !penable;
    xfer_err = pprot[1] || (paddr[OFF_W-1:0] != '0);
    null_wr  = pwrite && (pstrb == '0);
    // Saturating count of cycles reg_req has been held.
    cnt_d    = (cnt_q < CNT_W'(TIMEOUT)) ? cnt_q + CNT_W'(1) : cnt_q;
    timeout  = (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (setup) begin
            reg_addr_q  <= paddr;
            reg_we_q    <= pwrite;
            reg_wdata_q <= pwdata;
            reg_be_q    <= pwrite ? pstrb : '1;
            if (xfer_err) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= '0;
            end else if (null_wr) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b0;
              prdata_q  <= '0;
            end else begin
              state_q   <= REQ;
              reg_req_q <= 1'b1;
            end
          end
        end
        REQ: begin
          // psel is deliberately ignored here so an abandoned transfer
          // still finishes its single register-bus access.
          if (reg_ack) begin
            state_q   <= RESP;
            reg_req_q <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= reg_err;
            prdata_q  <= reg_we_q ? '0 : reg_rdata;
          end else if (timeout) begin
            state_q   <= RESP;
            reg_req_q <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          cnt_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign reg_req   = reg_req_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;

endmodule
